cache_controller: RTL and testbench

- Two-level (L1/L2) write-through cache controller in front of a small word-addressed backing memory.
- Models fixed access latencies for each level and returns read data on `data_out`.
- Sits between a simple level-sensitive request interface and on-chip storage; used as a latency/hit-path model for cache studies.
- All storage (L1, L2, backing memory) is internal to the block.

---
 rtl/cache_controller.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cache_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Two-level (L1/L2) write-through, write-allocate cache controller with an
// internal word-addressed backing memory. Each level is direct-mapped with one
// word per line and a fixed access latency, so the block doubles as a
// hit-path/latency model.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   wr_en     write request (level-sensitive, wins over read_en)
//   read_en   read request (level-sensitive)
//   addr      word address; only the low log2(MEM_DEPTH) bits are used
//   data      write data
//   data_out  last read result, held between reads
//
// Optional build macro CACHE_STATS_EN adds saturating 32-bit read counters:
//   l1_hit_cnt, l2_hit_cnt, mem_read_cnt
//
// Latency from acceptance: L1 hit L1_DELAY, L2 hit L1_DELAY+L2_DELAY,
// memory L1_DELAY+L2_DELAY+1; a DONE cycle always follows before IDLE.
// -----------------------------------------------------------------------------
module cache_controller #(
  parameter int WORD_SIZE = 32,
  parameter int L1_DELAY  = 3,
  parameter int L2_DELAY  = 3,
  parameter int L1_LINES  = 8,
  parameter int L2_LINES  = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 read_en,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data,
  output logic [WORD_SIZE-1:0] data_out
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]          l1_hit_cnt,
  output logic [31:0]          l2_hit_cnt,
  output logic [31:0]          mem_read_cnt
`endif
);

  localparam int ADDR_W   = $clog2(MEM_DEPTH);
  localparam int L1_IDX_W = $clog2(L1_LINES);
  localparam int L2_IDX_W = $clog2(L2_LINES);
  localparam int L1_TAG_W = ADDR_W - L1_IDX_W;
  localparam int L2_TAG_W = ADDR_W - L2_IDX_W;
  localparam int MAX_DLY  = (L1_DELAY > L2_DELAY) ? L1_DELAY : L2_DELAY;
  localparam int CNT_W    = $clog2(MAX_DLY + 1);

  typedef enum logic [2:0] {
    IDLE,
    L1_ACC,
    L2_ACC,
    MEM,
    DONE
  } state_t;

  // Control / datapath registers.
  state_t               state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic                 is_wr_q,    is_wr_d;
  logic [ADDR_W-1:0]    addr_q,     addr_d;
  logic [WORD_SIZE-1:0] wdata_q,    wdata_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;

  // Per-line valid bits and the memory written-bitmap are reset; the payload
  // arrays are not.
  logic [L1_LINES-1:0]  l1_valid_q,    l1_valid_d;
  logic [L2_LINES-1:0]  l2_valid_q,    l2_valid_d;
  logic [MEM_DEPTH-1:0] mem_written_q, mem_written_d;

  logic [L1_TAG_W-1:0]  l1_tag_mem  [L1_LINES];
  logic [WORD_SIZE-1:0] l1_data_mem [L1_LINES];
  logic [L2_TAG_W-1:0]  l2_tag_mem  [L2_LINES];
  logic [WORD_SIZE-1:0] l2_data_mem [L2_LINES];
  logic [WORD_SIZE-1:0] mem_data    [MEM_DEPTH];

  // Address split of the latched request.
  logic [L1_IDX_W-1:0]  l1_idx;
  logic [L1_TAG_W-1:0]  l1_tag;
  logic [L2_IDX_W-1:0]  l2_idx;
  logic [L2_TAG_W-1:0]  l2_tag;
  logic                 l1_hit, l2_hit;
  logic [WORD_SIZE-1:0] mem_word;
  logic                 l1_last, l2_last;
  logic                 rd_l1_hit, rd_l2_hit, rd_mem;

  // Storage write controls.
  logic                 l1_we, l2_we, mem_we;
  logic [WORD_SIZE-1:0] fill_word;

  // Address bits above the memory range alias and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[WORD_SIZE-1:ADDR_W];

  assign l1_idx = addr_q[L1_IDX_W-1:0];
  assign l1_tag = addr_q[ADDR_W-1:L1_IDX_W];
  assign l2_idx = addr_q[L2_IDX_W-1:0];
  assign l2_tag = addr_q[ADDR_W-1:L2_IDX_W];

  assign l1_hit   = l1_valid_q[l1_idx] && (l1_tag_mem[l1_idx] == l1_tag);
  assign l2_hit   = l2_valid_q[l2_idx] && (l2_tag_mem[l2_idx] == l2_tag);
  // Never-written words read as zero, independent of the uninitialised array.
  assign mem_word = mem_written_q[addr_q] ? mem_data[addr_q] : '0;

  assign l1_last = (cnt_q == CNT_W'(L1_DELAY - 1));
  assign l2_last = (cnt_q == CNT_W'(L2_DELAY - 1));

  // Read-completion classification (one-cycle pulses).
  assign rd_l1_hit = (state_q == L1_ACC) && l1_last && !is_wr_q && l1_hit;
  assign rd_l2_hit = (state_q == L2_ACC) && l2_last && !is_wr_q && l2_hit;
  assign rd_mem    = (state_q == MEM);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    data_out_d    = data_out_q;
    l1_we         = 1'b0;
    l2_we         = 1'b0;
    mem_we        = 1'b0;
    fill_word     = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (wr_en || read_en) begin
          state_d = L1_ACC;
          cnt_d   = '0;
          is_wr_d = wr_en;
          addr_d  = addr[ADDR_W-1:0];
          wdata_d = data;
        end
      end

      L1_ACC: begin
        if (l1_last) begin
          cnt_d = '0;
          if (rd_l1_hit) begin
            data_out_d = l1_data_mem[l1_idx];
            state_d    = DONE;
          end else begin
            state_d = L2_ACC;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      L2_ACC: begin
        if (l2_last) begin
          cnt_d = '0;
          if (is_wr_q) begin
            // Write-allocate into both levels plus write-through to memory.
            l1_we   = 1'b1;
            l2_we   = 1'b1;
            mem_we  = 1'b1;
            state_d = DONE;
          end else if (rd_l2_hit) begin
            l1_we      = 1'b1;
            fill_word  = l2_data_mem[l2_idx];
            data_out_d = l2_data_mem[l2_idx];
            state_d    = DONE;
          end else begin
            state_d = MEM;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      MEM: begin
        l1_we      = 1'b1;
        l2_we      = 1'b1;
        fill_word  = mem_word;
        data_out_d = mem_word;
        state_d    = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    l1_valid_d    = l1_valid_q;
    l2_valid_d    = l2_valid_q;
    mem_written_d = mem_written_q;
    if (l1_we)  l1_valid_d[l1_idx]    = 1'b1;
    if (l2_we)  l2_valid_d[l2_idx]    = 1'b1;
    if (mem_we) mem_written_d[addr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      is_wr_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      data_out_q    <= '0;
      l1_valid_q    <= '0;
      l2_valid_q    <= '0;
      mem_written_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      data_out_q    <= data_out_d;
      l1_valid_q    <= l1_valid_d;
      l2_valid_q    <= l2_valid_d;
      mem_written_q <= mem_written_d;
    end
  end

  // NOTE: payload arrays have no reset; the valid bits and written-bitmap
  // above decide whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (l1_we) begin
      l1_tag_mem[l1_idx]  <= l1_tag;
      l1_data_mem[l1_idx] <= fill_word;
    end
    if (l2_we) begin
      l2_tag_mem[l2_idx]  <= l2_tag;
      l2_data_mem[l2_idx] <= fill_word;
    end
    if (mem_we) begin
      mem_data[addr_q] <= fill_word;
    end
  end

  assign data_out = data_out_q;

`ifdef CACHE_STATS_EN
  logic [31:0] l1_hit_cnt_q,   l1_hit_cnt_d;
  logic [31:0] l2_hit_cnt_q,   l2_hit_cnt_d;
  logic [31:0] mem_read_cnt_q, mem_read_cnt_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    l1_hit_cnt_d   = l1_hit_cnt_q;
    l2_hit_cnt_d   = l2_hit_cnt_q;
    mem_read_cnt_d = mem_read_cnt_q;
    if (rd_l1_hit && !(&l1_hit_cnt_q))   l1_hit_cnt_d   = l1_hit_cnt_q + 32'd1;
    if (rd_l2_hit && !(&l2_hit_cnt_q))   l2_hit_cnt_d   = l2_hit_cnt_q + 32'd1;
    if (rd_mem    && !(&mem_read_cnt_q)) mem_read_cnt_d = mem_read_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l1_hit_cnt_q   <= '0;
      l2_hit_cnt_q   <= '0;
      mem_read_cnt_q <= '0;
    end else begin
      l1_hit_cnt_q   <= l1_hit_cnt_d;
      l2_hit_cnt_q   <= l2_hit_cnt_d;
      mem_read_cnt_q <= mem_read_cnt_d;
    end
  end

  assign l1_hit_cnt   = l1_hit_cnt_q;
  assign l2_hit_cnt   = l2_hit_cnt_q;
  assign mem_read_cnt = mem_read_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
//
// Directed self-checking bench for cache_controller with default parameters
// (L1_DELAY=3, L2_DELAY=3, L1_LINES=8, L2_LINES=32, MEM_DEPTH=256).
// Expected values and latencies are hand-derived from the address map:
//   0x10,0x20,0x30,0x40,0x50 all share L1 index 0;
//   L2 index: 0x10->16, 0x20->0, 0x30->16, 0x40->0, 0x50->16.
// Counter checks are compiled in only when CACHE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_cache_controller;

  localparam int LAT_L1  = 3;
  localparam int LAT_L2  = 6;
  localparam int LAT_MEM = 7;
  localparam int WR_IDLE = 7;   // cycles from acceptance until back in IDLE

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        read_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;
  logic [31:0] data_out;
`ifdef CACHE_STATS_EN
  logic [31:0] l1_hit_cnt, l2_hit_cnt, mem_read_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  cache_controller dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .read_en  (read_en),
    .addr     (addr),
    .data     (data),
    .data_out (data_out)
`ifdef CACHE_STATS_EN
    ,
    .l1_hit_cnt   (l1_hit_cnt),
    .l2_hit_cnt   (l2_hit_cnt),
    .mem_read_cnt (mem_read_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request for exactly the acceptance edge, then drop it and
  // scramble addr/data so the DUT must use its latched copy.
  task automatic issue(input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d);
    wr_en   = wr;
    read_en = rd;
    addr    = a;
    data    = d;
    tick(1);
    wr_en   = 1'b0;
    read_en = 1'b0;
    addr    = ~a;
    data    = ~d;
  endtask

  // Read with latency check: data_out must be unchanged one cycle before the
  // expected completion and equal exp right after it.
  task automatic read_and_check(input string name, input logic [31:0] a,
                                input logic [31:0] exp, input int lat);
    logic [31:0] prev;
    prev = data_out;
    issue(1'b0, 1'b1, a, 32'h0);
    tick(lat - 1);
    n_total++;
    if (data_out !== prev)
      $display("FAIL %s_early: data_out=%h expected unchanged %h", name, data_out, prev);
    else n_pass++;
    tick(1);
    n_total++;
    if (data_out !== exp)
      $display("FAIL %s: data_out=%h expected %h", name, data_out, exp);
    else n_pass++;
    tick(1);   // DONE -> IDLE
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, 1'b0, a, d);
    tick(WR_IDLE);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    n_total++;
    if (data_out !== 32'h0)
      $display("FAIL reset_data_out: data_out=%h expected 00000000", data_out);
    else n_pass++;
`ifdef CACHE_STATS_EN
    n_total++;
    if ({l1_hit_cnt, l2_hit_cnt, mem_read_cnt} !== 96'h0)
      $display("FAIL reset_counters: %h %h %h expected 0 0 0", l1_hit_cnt, l2_hit_cnt, mem_read_cnt);
    else n_pass++;
`endif
    rst = 1'b1;
    tick(1);
  endtask

  // Held read of a never-written address: memory path, returns zero.
  task automatic test_read_unwritten();
    read_en = 1'b1;
    addr    = 32'h11;
    tick(1);                 // acceptance
    tick(LAT_MEM);           // read completes
    n_total++;
    if (data_out !== 32'h0)
      $display("FAIL unwritten_read: data_out=%h expected 00000000", data_out);
    else n_pass++;
    tick(1);                 // back in IDLE; drop before re-acceptance
    read_en = 1'b0;
`ifdef CACHE_STATS_EN
    n_total++;
    if (mem_read_cnt !== 32'd1 || l1_hit_cnt !== 32'd0)
      $display("FAIL unwritten_cnt: mem=%0d l1=%0d expected mem=1 l1=0", mem_read_cnt, l1_hit_cnt);
    else n_pass++;
`endif
    tick(2);
  endtask

  task automatic test_l1_hit();
    write_word(32'h10, 32'hA5A5A5A5);
    tick(7);
    read_and_check("l1_hit_0x10", 32'h10, 32'hA5A5A5A5, LAT_L1);
  endtask

  // 0x20 evicts 0x10 from L1 line 0; 0x10 remains in L2 line 16.
  task automatic test_l2_hit();
    write_word(32'h20, 32'h5A5A5A5A);
    read_and_check("l1_hit_0x20", 32'h20, 32'h5A5A5A5A, LAT_L1);
    read_and_check("l2_hit_0x10", 32'h10, 32'hA5A5A5A5, LAT_L2);
  endtask

  // Write 0x30 (evicts 0x10 from L2 line 16) must not disturb data_out.
  task automatic test_write_no_disturb();
    issue(1'b1, 1'b0, 32'h30, 32'h12345678);
    for (int i = 0; i < WR_IDLE; i++) begin
      tick(1);
      n_total++;
      if (data_out !== 32'hA5A5A5A5)
        $display("FAIL write_hold_c%0d: data_out=%h expected a5a5a5a5", i, data_out);
      else n_pass++;
    end
    read_and_check("l2_hit_0x20", 32'h20, 32'h5A5A5A5A, LAT_L2);
    read_and_check("mem_0x10",    32'h10, 32'hA5A5A5A5, LAT_MEM);
    read_and_check("mem_0x30",    32'h30, 32'h12345678, LAT_MEM);
  endtask

  // wr_en and read_en together: the write wins, data_out is left alone.
  task automatic test_simultaneous();
    issue(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    tick(WR_IDLE);
    n_total++;
    if (data_out !== 32'h12345678)
      $display("FAIL simul_no_read: data_out=%h expected 12345678", data_out);
    else n_pass++;
    read_and_check("simul_0x40", 32'h40, 32'hDEADBEEF, LAT_L1);
  endtask

  // Upper address bits alias onto the same word.
  task automatic test_alias();
    write_word(32'h0000_0141, 32'hCAFEF00D);
    read_and_check("alias_0x41", 32'h41, 32'hCAFEF00D, LAT_L1);
  endtask

  // issue() scrambles addr/data right after acceptance.
  task automatic test_input_latch();
    write_word(32'h50, 32'h11112222);
    read_and_check("latch_0x50", 32'h50, 32'h11112222, LAT_L1);
`ifdef CACHE_STATS_EN
    n_total++;
    if (l1_hit_cnt !== 32'd5 || l2_hit_cnt !== 32'd2 || mem_read_cnt !== 32'd3)
      $display("FAIL stats_totals: l1=%0d l2=%0d mem=%0d expected 5 2 3",
               l1_hit_cnt, l2_hit_cnt, mem_read_cnt);
    else n_pass++;
`endif
  endtask

  // Reset while the read sits in L2_ACC.
  task automatic test_reset_mid();
    issue(1'b0, 1'b1, 32'h10, 32'h0);
    tick(4);
    rst = 1'b0;
    #1;
    n_total++;
    if (data_out !== 32'h0)
      $display("FAIL reset_mid_data_out: data_out=%h expected 00000000", data_out);
    else n_pass++;
    tick(1);
    rst = 1'b1;
    tick(1);
    issue(1'b0, 1'b1, 32'h50, 32'h0);
    tick(LAT_MEM);
    n_total++;
    if (data_out !== 32'h0)
      $display("FAIL reset_mid_0x50: data_out=%h expected 00000000", data_out);
    else n_pass++;
    tick(1);
    read_and_check("reset_mid_0x20", 32'h20, 32'h0, LAT_MEM);
`ifdef CACHE_STATS_EN
    n_total++;
    if (mem_read_cnt !== 32'd2 || l1_hit_cnt !== 32'd0 || l2_hit_cnt !== 32'd0)
      $display("FAIL reset_mid_cnt: l1=%0d l2=%0d mem=%0d expected 0 0 2",
               l1_hit_cnt, l2_hit_cnt, mem_read_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_read_unwritten();
    test_l1_hit();
    test_l2_hit();
    test_write_no_disturb();
    test_simultaneous();
    test_alias();
    test_input_latch();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
